multicycle_csa_sequencer: RTL

Multi-cycle wide adder controller. Accepts one W-bit operand pair with valid/ready, then slices it into N-bit chunks. Each cycle it feeds one chunk, LSB first, to a single carry_select_adder_block instance and registers that instance's carry-out as the next chunk's carry-in. It collects the chunk sums into a W-bit result, presented with valid/ready, so the design trades area for latency against the fully parallel adders.

---
 rtl/adder_pkg.sv | 28 ++
 rtl/carry_select_adder_block.sv | 22 ++
 rtl/multicycle_csa_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the multi-cycle adder: FSM encoding, clog2 helper, chunk-count macro.
`ifndef ADDER_PKG_SV
`define ADDER_PKG_SV

// Number of N-bit chunks in a W-bit operand.
`define ADDER_CHUNKS(w, n) ((w) / (n))

package adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

`endif

// File: rtl/carry_select_adder_block.sv
// N-bit carry-select adder: both carry-in outcomes are precomputed and the real cin picks one.
module carry_select_adder_block #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] sum0;
  logic [N:0] sum1;

  // Precompute both carry-in cases, then select.
  always_comb begin
    sum0        = {1'b0, a} + {1'b0, b};
    sum1        = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, 1'b1};
    {cout, sum} = cin ? sum1 : sum0;
  end

endmodule

// File: rtl/multicycle_csa_sequencer.sv
// Multi-cycle wide adder: one N-bit carry-select chunk per cycle, LSB first, carry registered
// between chunks. Operands and results use valid/ready handshakes with no overlap.
module multicycle_csa_sequencer
  import adder_pkg::*;
#(
  parameter int unsigned W = 32,
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int unsigned Chunks  = `ADDER_CHUNKS(W, N);
  localparam int unsigned CntW    = (clog2(Chunks) > 0) ? clog2(Chunks) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Chunks - 1);

  if (((W % N) != 0) || (W < N)) begin : g_bad_params
    $error("multicycle_csa_sequencer: W must be a non-zero multiple of N");
  end

  state_e state_q, state_d;

  logic [W-1:0]    a_sh_q, b_sh_q, sum_sh_q, sum_q;
  logic [W-1:0]    a_next, b_next, sum_sh_next;
  logic [CntW-1:0] cnt_q;
  logic            carry_q, cout_q, overflow_q, sa_q, sb_q;
  logic [N-1:0]    csa_sum;
  logic            csa_cout;
  logic            accept, step, last, ovf_next;

  carry_select_adder_block #(
    .N(N)
  ) u_csa (
    .a   (a_sh_q[N-1:0]),
    .b   (b_sh_q[N-1:0]),
    .cin (carry_q),
    .sum (csa_sum),
    .cout(csa_cout)
  );

  // Shift datapath: operands move down by one chunk, results enter from the top.
  if (Chunks > 1) begin : g_multi
    assign a_next      = {{N{1'b0}}, a_sh_q[W-1:N]};
    assign b_next      = {{N{1'b0}}, b_sh_q[W-1:N]};
    assign sum_sh_next = {csa_sum, sum_sh_q[W-1:N]};
  end else begin : g_single
    assign a_next      = '0;
    assign b_next      = '0;
    assign sum_sh_next = csa_sum;
  end

  assign accept    = in_valid && (state_q == StIdle);
  assign step      = (state_q == StRun);
  assign last      = step && (cnt_q == LastCnt);
  assign ovf_next  = (sa_q == sb_q) && (sum_sh_next[W-1] != sa_q);

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state decode; handshakes depend only on registered state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)  state_d = StRun;
      StRun:   if (last)      state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  // Datapath: load on accept, shift one chunk per RUN cycle, latch outputs on the last chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      sum_sh_q   <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
    end else if (accept) begin
      a_sh_q  <= in_a;
      b_sh_q  <= in_b;
      carry_q <= in_cin;
      cnt_q   <= '0;
      sa_q    <= in_a[W-1];
      sb_q    <= in_b[W-1];
    end else if (step) begin
      a_sh_q   <= a_next;
      b_sh_q   <= b_next;
      sum_sh_q <= sum_sh_next;
      carry_q  <= csa_cout;
      cnt_q    <= cnt_q + 1'b1;
      if (last) begin
        sum_q      <= sum_sh_next;
        cout_q     <= csa_cout;
        overflow_q <= ovf_next;
      end
    end
  end

endmodule
